// File: rtl/serial_compare_unit.sv
// serial_compare_unit: digit-serial A-B engine producing NZCV and derived compare conditions
// Ports: clk, reset_n (async, active-low); start requests an op in IDLE, latching a/b;
//   busy high in RUN; done pulses one cycle as result/flags update;
//   result = a-b; n,z,c,v flags (c = no-borrow); hs,ls,hi,lo unsigned; ge,le,gt,lt signed.
module serial_compare_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             hs,
  output logic             ls,
  output logic             hi,
  output logic             lo,
  output logic             ge,
  output logic             le,
  output logic             gt,
  output logic             lt
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_compare_unit: WIDTH must be a multiple of DIGIT");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic             r_carry, r_zacc;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT:0]   w_add;
  logic [DIGIT-1:0] w_sum;
  logic             w_cy, w_cin_msb, w_last;
  logic [WIDTH-1:0] w_acc_next;
  assign w_add      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  assign w_sum      = w_add[DIGIT-1:0];
  assign w_cy       = w_add[DIGIT];
  // carry into the digit's top bit, recovered from the sum bit; on the last digit this is the carry into bit WIDTH-1
  assign w_cin_msb  = w_sum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
  assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));
  assign w_last     = r_cnt == CW'(N - 1);
  always_comb begin
    w_next = r_state;
    busy   = r_state == RUN;
    done   = r_state == DONE;
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_cnt   <= '0;
      result  <= '0;
      n       <= 1'b0;
      z       <= 1'b0;
      c       <= 1'b0;
      v       <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a     <= a;
      r_b     <= ~b;
      r_carry <= 1'b1;
      r_zacc  <= 1'b1;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_acc_next;
      r_carry <= w_cy;
      r_zacc  <= r_zacc & (w_sum == '0);
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        result <= w_acc_next;
        n      <= w_sum[DIGIT-1];
        z      <= r_zacc & (w_sum == '0);
        c      <= w_cy;
        v      <= w_cin_msb ^ w_cy;
      end
    end
  end
  assign hs = c;
  assign lo = ~c;
  assign hi = c & ~z;
  assign ls = ~c | z;
  assign ge = n == v;
  assign lt = n != v;
  assign gt = ~z & (n == v);
  assign le = z | (n != v);
endmodule

// File: tb/tb_serial_compare_unit.sv
// tb_serial_compare_unit: directed vectors plus multi-cycle corner sequences for serial_compare_unit
module tb_serial_compare_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic [31:0] a = '0, b = '0, a2 = '0, b2 = '0;
  logic        busy, done, busy2, done2;
  logic [31:0] result, result2;
  logic        n, z, c, v, hs, ls, hi, lo, ge, le, gt, lt;
  logic        n2, z2, c2, v2, hs2, ls2, hi2, lo2, ge2, le2, gt2, lt2;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  serial_compare_unit #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .n(n), .z(z), .c(c), .v(v), .hs(hs), .ls(ls), .hi(hi), .lo(lo),
    .ge(ge), .le(le), .gt(gt), .lt(lt));
  serial_compare_unit #(.WIDTH(32), .DIGIT(32)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .a(a2), .b(b2), .busy(busy2), .done(done2),
    .result(result2), .n(n2), .z(z2), .c(c2), .v(v2), .hs(hs2), .ls(ls2), .hi(hi2), .lo(lo2),
    .ge(ge2), .le(le2), .gt(gt2), .lt(lt2));
  typedef struct {
    logic [31:0] a, b, res;
    logic [3:0]  nzcv;
    logic [7:0]  cond;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] cond_of(input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    return {fc, ~fc | fz, fc & ~fz, ~fc, fn == fv, fz | (fn != fv), ~fz & (fn == fv), fn != fv};
  endfunction
  task automatic golden(input logic [31:0] ga, input logic [31:0] gb,
                        output logic [31:0] gr, output logic [3:0] gf);
    logic [32:0] full;
    logic        gv;
    full = {1'b0, ga} + {1'b0, ~gb} + 33'd1;
    gr   = full[31:0];
    gv   = (ga[31] != gb[31]) && (gr[31] != ga[31]);
    gf   = {gr[31], gr == 32'd0, full[32], gv};
  endtask
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input bit pulse,
                       output int lat, output logic [31:0] mid_res, output logic mid_busy);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0; mid_res = 'x; mid_busy = 1'bx;
    while (done !== 1'b1 && lat < 40) begin
      start = pulse && lat == 3;
      @(posedge clk);
      #1;
      lat++;
      if (lat == 4) begin
        mid_res = result;
        mid_busy = busy;
      end
    end
    start = 1'b0;
  endtask
  initial begin
    int          lat;
    logic [31:0] mid_res, gr;
    logic        mid_busy;
    logic [3:0]  gf;
    vecs[0] = '{32'd255, 32'd25, 32'd230, 4'b0010, 8'b1010_1010};
    vecs[1] = '{32'd0, 32'd0, 32'd0, 4'b0110, 8'b1100_1100};
    vecs[2] = '{32'h8000_0000, 32'h7fff_ffff, 32'd1, 4'b0011, 8'b1010_0101};
    vecs[3] = '{32'd457, 32'd498, 32'hffff_ffd7, 4'b1000, 8'b0101_0101};
    vecs[4] = '{32'd5, 32'd5, 32'd0, 4'b0110, 8'b1100_1100};
    vecs[5] = '{32'h7fff_ffff, 32'hffff_ffff, 32'h8000_0000, 4'b1001, 8'b0101_1010};
    #12;
    chk("reset_result", result, 32'd0);
    chk("reset_nzcv", {n, z, c, v}, 4'b0000);
    chk("reset_cond", {hs, ls, hi, lo, ge, le, gt, lt}, 8'b0101_1010);
    chk("reset_busy_done", {busy, done}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, 1'b0, lat, mid_res, mid_busy);
      chk($sformatf("v%0d_latency", i), lat, 8);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_nzcv", i), {n, z, c, v}, vecs[i].nzcv);
      chk($sformatf("v%0d_cond", i), {hs, ls, hi, lo, ge, le, gt, lt}, vecs[i].cond);
      chk($sformatf("v%0d_busy_mid", i), mid_busy, 1'b1);
      chk($sformatf("v%0d_result_held", i), mid_res, (i == 0) ? 32'd0 : vecs[i-1].res);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {done, busy}, 2'b00);
    end
    do_op(32'd457, 32'd498, 1'b1, lat, mid_res, mid_busy);
    chk("pulse_latency", lat, 8);
    chk("pulse_result", result, 32'hffff_ffd7);
    chk("pulse_nzcv", {n, z, c, v}, 4'b1000);
    chk("pulse_cond", {hs, ls, hi, lo, ge, le, gt, lt}, 8'b0101_0101);
    chk("pulse_result_held", mid_res, 32'h8000_0000);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) begin
        chk("pulse_no_requeue", {done, busy}, 2'b00);
        break;
      end
    end
    chk("pulse_idle_after", {done, busy}, 2'b00);
    @(negedge clk);
    a = 32'h8000_abcd; b = 32'h8fff_ffff; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrun_rst_result", result, 32'd0);
    chk("midrun_rst_nzcv", {n, z, c, v}, 4'b0000);
    chk("midrun_rst_cond", {hs, ls, hi, lo, ge, le, gt, lt}, 8'b0101_1010);
    chk("midrun_rst_busy_done", {busy, done}, 2'b00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) begin
        chk("midrun_rst_discard", {done, busy}, 2'b00);
        break;
      end
    end
    do_op(32'h8000_abcd, 32'h8fff_ffff, 1'b0, lat, mid_res, mid_busy);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_result", result, 32'hf000_abce);
    chk("post_rst_nzcv", {n, z, c, v}, 4'b1000);
    chk("post_rst_cond", {hs, ls, hi, lo, ge, le, gt, lt}, 8'b0101_0101);
    start2 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a2 = $urandom;
      b2 = (i % 10 == 0) ? a2 : ((i % 10 == 1) ? ~a2 : $urandom);
      golden(a2, b2, gr, gf);
      @(posedge clk);
      #1;
      chk($sformatf("d32_busy_%0d", i), {busy2, done2}, 2'b10);
      @(posedge clk);
      #1;
      chk($sformatf("d32_op_%0d", i),
          {done2, result2, n2, z2, c2, v2, hs2, ls2, hi2, lo2, ge2, le2, gt2, lt2},
          {1'b1, gr, gf, cond_of(gf)});
      @(posedge clk);
    end
    start2 = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
